jtag_tap_responder: RTL

JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

---
 rtl/jtag_tap_pkg.sv | 34 +++
 rtl/jtag_tck_sync.sv | 59 +++++
 rtl/jtag_tap_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - TAP state encodings, instruction opcodes and DR select codes
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  localparam int unsigned OPC_IDCODE = 1;
  localparam int unsigned OPC_USER   = 2;
  // BYPASS is this bit replicated across the full IR width
  localparam logic OPC_BYPASS_BIT = 1'b1;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_USER,
    SEL_IDCODE
  } dr_sel_e;

endpackage

// File: rtl/jtag_tck_sync.sv
// rtl/jtag_tck_sync.sv - CLK-domain synchronizers for TCK/TMS/TDI and TCK edge strobes
module jtag_tck_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic TCK,
  input  logic TMS,
  input  logic TDI,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic tck_meta_q, tck_meta_d;
  logic tck_sync_q, tck_sync_d;
  logic tck_lvl_q, tck_lvl_d;
  logic tms_meta_q, tms_meta_d;
  logic tms_sync_q, tms_sync_d;
  logic tdi_meta_q, tdi_meta_d;
  logic tdi_sync_q, tdi_sync_d;

  always_comb begin
    tck_meta_d = TCK;
    tck_sync_d = tck_meta_q;
    tms_meta_d = TMS;
    tms_sync_d = tms_meta_q;
    tdi_meta_d = TDI;
    tdi_sync_d = tdi_meta_q;
    // The accepted TCK level only moves once two consecutive samples agree
    tck_lvl_d = tck_lvl_q;
    if (tck_meta_q == tck_sync_q) tck_lvl_d = tck_sync_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tck_meta_q <= 1'b0;
      tck_sync_q <= 1'b0;
      tck_lvl_q  <= 1'b0;
      tms_meta_q <= 1'b0;
      tms_sync_q <= 1'b0;
      tdi_meta_q <= 1'b0;
      tdi_sync_q <= 1'b0;
    end else begin
      tck_meta_q <= tck_meta_d;
      tck_sync_q <= tck_sync_d;
      tck_lvl_q  <= tck_lvl_d;
      tms_meta_q <= tms_meta_d;
      tms_sync_q <= tms_sync_d;
      tdi_meta_q <= tdi_meta_d;
      tdi_sync_q <= tdi_sync_d;
    end
  end

  assign tck_rise = tck_sync_q & tck_meta_q & ~tck_lvl_q;
  assign tck_fall = ~tck_sync_q & ~tck_meta_q & tck_lvl_q;
  assign tms_s    = tms_sync_q;
  assign tdi_s    = tdi_sync_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// rtl/jtag_tap_responder.sv - oversampled IEEE 1149.1 TAP with BYPASS/USER DRs
// JTAG_TAP_IDCODE_EN adds the IDCODE register and makes IDCODE the reset instruction.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int          C_IR_LENGTH = 4,
  parameter int          C_DR_LENGTH = 32,
  parameter logic [31:0] C_IDCODE    = 32'h1000_0093
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   TCK,
  input  logic                   TMS,
  input  logic                   TDI,
  output logic                   TDO,
  input  logic [C_DR_LENGTH-1:0] DR_IN,
  output logic [C_DR_LENGTH-1:0] DR_OUT,
  output logic                   DR_UPDATE,
  output logic [3:0]             TAP_STATE
);

  localparam logic [C_IR_LENGTH-1:0] IR_BYPASS  = {C_IR_LENGTH{OPC_BYPASS_BIT}};
  localparam logic [C_IR_LENGTH-1:0] IR_USER    = C_IR_LENGTH'(OPC_USER);
  localparam logic [C_IR_LENGTH-1:0] IR_IDCODE  = C_IR_LENGTH'(OPC_IDCODE);
  localparam logic [C_IR_LENGTH-1:0] IR_CAPTURE = C_IR_LENGTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [C_IR_LENGTH-1:0] IR_DEFAULT = IR_IDCODE;
`else
  localparam logic [C_IR_LENGTH-1:0] IR_DEFAULT = IR_BYPASS;
`endif

  logic tck_rise, tck_fall, tms_s, tdi_s;

  tap_state_e             state_q, state_d;
  logic [C_IR_LENGTH-1:0] ir_shift_q, ir_shift_d;
  logic [C_IR_LENGTH-1:0] ir_q, ir_d;
  logic                   bypass_q, bypass_d;
  logic [C_DR_LENGTH-1:0] user_q, user_d;
  logic [C_DR_LENGTH-1:0] dr_out_q, dr_out_d;
  logic                   dr_update_q, dr_update_d;
  logic                   tdo_q, tdo_d;
  dr_sel_e                sel;
  logic                   dr_lsb;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]            idc_q, idc_d;
`else
  logic                   unused_cfg;
  assign unused_cfg = ^{C_IDCODE, IR_IDCODE};
`endif

  jtag_tck_sync u_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .TCK      (TCK),
    .TMS      (TMS),
    .TDI      (TDI),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  always_comb begin
    sel = SEL_BYPASS;
    if (ir_q == IR_BYPASS) sel = SEL_BYPASS;
    else if (ir_q == IR_USER) sel = SEL_USER;
`ifdef JTAG_TAP_IDCODE_EN
    else if (ir_q == IR_IDCODE) sel = SEL_IDCODE;
`endif
  end

  always_comb begin
    dr_lsb = bypass_q;
    if (sel == SEL_USER) dr_lsb = user_q[0];
`ifdef JTAG_TAP_IDCODE_EN
    else if (sel == SEL_IDCODE) dr_lsb = idc_q[0];
`endif
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TAP_RESET:      state_d = tms_s ? TAP_RESET     : TAP_RUN_IDLE;
        TAP_RUN_IDLE:   state_d = tms_s ? TAP_SELECT_DR : TAP_RUN_IDLE;
        TAP_SELECT_DR:  state_d = tms_s ? TAP_SELECT_IR : TAP_CAPTURE_DR;
        TAP_CAPTURE_DR: state_d = tms_s ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
        TAP_SHIFT_DR:   state_d = tms_s ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
        TAP_EXIT1_DR:   state_d = tms_s ? TAP_UPDATE_DR : TAP_PAUSE_DR;
        TAP_PAUSE_DR:   state_d = tms_s ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
        TAP_EXIT2_DR:   state_d = tms_s ? TAP_UPDATE_DR : TAP_SHIFT_DR;
        TAP_UPDATE_DR:  state_d = tms_s ? TAP_SELECT_DR : TAP_RUN_IDLE;
        TAP_SELECT_IR:  state_d = tms_s ? TAP_RESET     : TAP_CAPTURE_IR;
        TAP_CAPTURE_IR: state_d = tms_s ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
        TAP_SHIFT_IR:   state_d = tms_s ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
        TAP_EXIT1_IR:   state_d = tms_s ? TAP_UPDATE_IR : TAP_PAUSE_IR;
        TAP_PAUSE_IR:   state_d = tms_s ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
        TAP_EXIT2_IR:   state_d = tms_s ? TAP_UPDATE_IR : TAP_SHIFT_IR;
        TAP_UPDATE_IR:  state_d = tms_s ? TAP_SELECT_DR : TAP_RUN_IDLE;
        default:        state_d = TAP_RESET;
      endcase
    end
  end

  always_comb begin
    ir_shift_d  = ir_shift_q;
    ir_d        = ir_q;
    bypass_d    = bypass_q;
    user_d      = user_q;
    dr_out_d    = dr_out_q;
    dr_update_d = 1'b0;
    tdo_d       = tdo_q;
`ifdef JTAG_TAP_IDCODE_EN
    idc_d       = idc_q;
`endif
    if (state_q == TAP_RESET) ir_d = IR_DEFAULT;
    if (tck_rise) begin
      case (state_q)
        TAP_CAPTURE_IR: ir_shift_d = IR_CAPTURE;
        TAP_SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[C_IR_LENGTH-1:1]};
        TAP_UPDATE_IR:  ir_d = ir_shift_q;
        TAP_CAPTURE_DR: begin
          if (sel == SEL_BYPASS) bypass_d = 1'b0;
          if (sel == SEL_USER) user_d = DR_IN;
`ifdef JTAG_TAP_IDCODE_EN
          if (sel == SEL_IDCODE) idc_d = C_IDCODE;
`endif
        end
        TAP_SHIFT_DR: begin
          if (sel == SEL_BYPASS) bypass_d = tdi_s;
          if (sel == SEL_USER) user_d = {tdi_s, user_q[C_DR_LENGTH-1:1]};
`ifdef JTAG_TAP_IDCODE_EN
          if (sel == SEL_IDCODE) idc_d = {tdi_s, idc_q[31:1]};
`endif
        end
        TAP_UPDATE_DR: begin
          if (sel == SEL_USER) begin
            dr_out_d    = user_q;
            dr_update_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (tck_fall) begin
      tdo_d = 1'b0;
      if (state_q == TAP_SHIFT_IR) tdo_d = ir_shift_q[0];
      else if (state_q == TAP_SHIFT_DR) tdo_d = dr_lsb;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= TAP_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_shift_q  <= '0;
      ir_q        <= IR_DEFAULT;
      bypass_q    <= 1'b0;
      user_q      <= '0;
      dr_out_q    <= '0;
      dr_update_q <= 1'b0;
      tdo_q       <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idc_q       <= '0;
`endif
    end else begin
      ir_shift_q  <= ir_shift_d;
      ir_q        <= ir_d;
      bypass_q    <= bypass_d;
      user_q      <= user_d;
      dr_out_q    <= dr_out_d;
      dr_update_q <= dr_update_d;
      tdo_q       <= tdo_d;
`ifdef JTAG_TAP_IDCODE_EN
      idc_q       <= idc_d;
`endif
    end
  end

  assign TDO       = tdo_q;
  assign DR_OUT    = dr_out_q;
  assign DR_UPDATE = dr_update_q;
  assign TAP_STATE = state_q;

endmodule
